// File: rtl/user_gpio_capture.sv
// user_gpio_capture: synchronises a GPIO capture line, detects the selected
// edges, timestamps the interval between accepted edges and queues
// {first, pol, delta} in a small FIFO that software drains over APB4.
// Optional input glitch filter is built when USER_CAP_GLITCH_FILTER_EN is defined.
module user_gpio_capture #(
   parameter logic [7:0] ID          = 8'd255,
   parameter int         SYNC_STAGES = 2,
   parameter int         FIFO_DEPTH  = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        cap_i,
   input  logic        apb_psel_i,
   input  logic        apb_penable_i,
   input  logic        apb_pwrite_i,
   input  logic [7:0]  apb_paddr_i,
   input  logic [31:0] apb_pwdata_i,
   output logic [31:0] apb_prdata_o,
   output logic        apb_pready_o,
   output logic        apb_pslverr_o,
   output logic        irq_o
);

   localparam int         PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [4:0] DEPTH_L = 5'(FIFO_DEPTH);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;
   logic                   r_str_vld;
   logic                   r_str_pol;
   logic                   r_en;
   logic [1:0]             r_edge;
   logic                   r_irq_en;
   logic                   r_ovf;
   logic                   r_first;
   logic [15:0]            r_cnt;
   logic [17:0]            r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       r_wptr;
   logic [PTR_W-1:0]       r_rptr;
   logic [4:0]             r_level;
   logic                   r_irq;

   logic        w_sync;
   logic        w_level;
   logic        w_rise;
   logic        w_fall;
   logic        w_wr;
   logic        w_rd;
   logic        w_a_id;
   logic        w_a_ctrl;
   logic        w_a_stat;
   logic        w_a_data;
   logic        w_clr;
   logic        w_empty;
   logic        w_full;
   logic        w_pop;
   logic        w_push_req;
   logic        w_push;
   logic        w_ovf_set;
   logic [7:0]  w_filt_rd;
   logic        w_unused;

   assign apb_pready_o  = 1'b1;
   assign apb_pslverr_o = 1'b0;
   assign irq_o         = r_irq;

   // Input synchroniser chain
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_sync <= '0;
      else       r_sync <= {r_sync[SYNC_STAGES-2:0], cap_i};
   end

   assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef USER_CAP_GLITCH_FILTER_EN
   logic [7:0] r_filt;
   logic [7:0] r_stab;
   logic       r_last;
   logic       r_acc;
   logic [7:0] w_stab_cur;

   // Stability run length (cycles minus one) and accepted level; FILT=0 is transparent
   always_comb begin
      w_stab_cur = 8'd0;
      if (w_sync == r_last) w_stab_cur = (r_stab == 8'hFF) ? 8'hFF : r_stab + 8'd1;
      w_level = (w_stab_cur >= r_filt) ? w_sync : r_acc;
   end

   // Filter state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last <= 1'b0;
         r_stab <= 8'd0;
         r_acc  <= 1'b0;
      end else begin
         r_last <= w_sync;
         r_stab <= w_stab_cur;
         r_acc  <= w_level;
      end
   end

   // Filter threshold lives in CTRL[15:8]
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                r_filt <= 8'd0;
      else if (w_wr && w_a_ctrl) r_filt <= apb_pwdata_i[15:8];
   end

   assign w_filt_rd = r_filt;
   assign w_unused  = &{1'b0, apb_pwdata_i[31:16], apb_pwdata_i[7:5]};
`else
   assign w_level   = w_sync;
   assign w_filt_rd = 8'd0;
   assign w_unused  = &{1'b0, apb_pwdata_i[31:8], apb_pwdata_i[7:5]};
`endif

   assign w_rise = w_level & ~r_prev;
   assign w_fall = ~w_level & r_prev;

   // Compare flop and registered qualified-edge strobe feeding the FIFO push
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_prev    <= 1'b0;
         r_str_vld <= 1'b0;
         r_str_pol <= 1'b0;
      end else begin
         r_prev    <= w_level;
         r_str_vld <= r_en & ((r_edge[0] & w_rise) | (r_edge[1] & w_fall));
         r_str_pol <= w_rise;
      end
   end

   assign w_wr     = apb_psel_i & apb_penable_i & apb_pwrite_i;
   assign w_rd     = apb_psel_i & apb_penable_i & ~apb_pwrite_i;
   assign w_a_id   = (apb_paddr_i == 8'h00);
   assign w_a_ctrl = (apb_paddr_i == 8'h04);
   assign w_a_stat = (apb_paddr_i == 8'h08);
   assign w_a_data = (apb_paddr_i == 8'h0C);
   assign w_clr    = w_wr & w_a_ctrl & apb_pwdata_i[3];

   assign w_empty    = (r_level == 5'd0);
   assign w_full     = (r_level == DEPTH_L);
   assign w_pop      = w_rd & w_a_data & ~w_empty;
   // clr discards an edge arriving in the same cycle
   assign w_push_req = r_str_vld & r_en & ~w_clr;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push
   assign w_push     = w_push_req & (~w_full | w_pop);
   assign w_ovf_set  = w_push_req & w_full & ~w_pop;

   // CTRL register (clr is a strobe, never stored)
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_en     <= 1'b0;
         r_edge   <= 2'b00;
         r_irq_en <= 1'b0;
      end else if (w_wr && w_a_ctrl) begin
         r_en     <= apb_pwdata_i[0];
         r_edge   <= apb_pwdata_i[2:1];
         r_irq_en <= apb_pwdata_i[4];
      end
   end

   // Interval counter and first-entry flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt   <= 16'd0;
         r_first <= 1'b1;
      end else if (!r_en || w_clr) begin
         r_cnt   <= 16'd0;
         r_first <= 1'b1;
      end else if (w_push_req) begin
         r_cnt   <= 16'd1;
         r_first <= 1'b0;
      end else if (r_cnt != 16'hFFFF) begin
         r_cnt   <= r_cnt + 16'd1;
      end
   end

   // Capture FIFO storage, pointers and level
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 18'd0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= 5'd0;
      end else if (w_clr) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= 5'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= {r_first, r_str_pol, r_cnt};
            r_wptr        <= r_wptr + PTR_W'(1);
         end
         if (w_pop) r_rptr <= r_rptr + PTR_W'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 5'd1;
            2'b01:   r_level <= r_level - 5'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Sticky overflow; a new overflow wins over a same-cycle software clear
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)                                     r_ovf <= 1'b0;
      else if (w_clr)                                r_ovf <= 1'b0;
      else if (w_ovf_set)                            r_ovf <= 1'b1;
      else if (w_wr && w_a_stat && apb_pwdata_i[2])  r_ovf <= 1'b0;
   end

   // Interrupt follows pending entries one cycle late
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) r_irq <= 1'b0;
      else       r_irq <= r_irq_en & ~w_empty;
   end

   // Read mux, zero outside a read access
   always_comb begin
      apb_prdata_o = 32'd0;
      if (w_rd) begin
         if (w_a_id)   apb_prdata_o = {24'd0, ID};
         if (w_a_ctrl) apb_prdata_o = {16'd0, w_filt_rd, 3'd0, r_irq_en, 1'b0, r_edge, r_en};
         if (w_a_stat) apb_prdata_o = {23'd0, r_level, 1'b0, r_ovf, w_full, w_empty};
         if (w_a_data && !w_empty) apb_prdata_o = {14'd0, r_mem[r_rptr]};
      end
   end

endmodule
